fetch_stage: RTL and testbench

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/fetch_stage_if.sv | 52 +++++
 rtl/fetch_stage.sv | 134 +++++++++++++
 tb/tb_fetch_stage.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_stage_if.sv
// Fetch-stage bus: instruction-memory port, hazard/redirect controls and IF/ID outputs.
// The master modport is the fetch stage itself; slave is the surrounding pipeline/memory.
interface fetch_stage_if;
   // Control from hazard unit / branch resolution
   logic        stall;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        halt_req;
   // Instruction memory (combinational read)
   logic [31:0] Instruction;
   logic [31:0] Address;
   // IF/ID register and status
   logic [31:0] ifid_instr;
   logic [31:0] ifid_pc;
   logic [31:0] ifid_pc_plus1;
   logic        ifid_valid;
   logic        halted;
   logic [15:0] fetch_cnt;
   logic [15:0] bubble_cnt;

   modport master (
      input  stall,
      input  redirect,
      input  redirect_pc,
      input  halt_req,
      input  Instruction,
      output Address,
      output ifid_instr,
      output ifid_pc,
      output ifid_pc_plus1,
      output ifid_valid,
      output halted,
      output fetch_cnt,
      output bubble_cnt
   );

   modport slave (
      output stall,
      output redirect,
      output redirect_pc,
      output halt_req,
      output Instruction,
      input  Address,
      input  ifid_instr,
      input  ifid_pc,
      input  ifid_pc_plus1,
      input  ifid_valid,
      input  halted,
      input  fetch_cnt,
      input  bubble_cnt
   );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch stage: word-indexed PC, IF/ID pipeline register, BOOT/RUN/HALT control
// and saturating fetch/bubble counters. Reset is synchronous and active-low.
module fetch_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
   input  logic                 clk,
   input  logic                 rst_n,
   fetch_stage_if.master        bus
);

   typedef enum logic [1:0] {
      StBoot = 2'd0,
      StRun  = 2'd1,
      StHalt = 2'd2
   } state_e;

   state_e      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] ifid_instr_q, ifid_instr_d;
   logic [31:0] ifid_pc_q, ifid_pc_d;
   logic [31:0] ifid_pc_plus1_q, ifid_pc_plus1_d;
   logic        ifid_valid_q, ifid_valid_d;
   logic [15:0] fetch_cnt_q, fetch_cnt_d;
   logic [15:0] bubble_cnt_q, bubble_cnt_d;

   logic [31:0] pc_plus1;
   logic        load_bubble;
   logic        fetch_inc;
   logic        bubble_inc;

   // Wraps naturally from 32'hFFFFFFFF to 0
   assign pc_plus1 = pc_q + 32'd1;

   // Next-state and IF/ID control; redirect beats halt_req beats stall in RUN
   always_comb begin
      state_d         = state_q;
      pc_d            = pc_q;
      ifid_instr_d    = ifid_instr_q;
      ifid_pc_d       = ifid_pc_q;
      ifid_pc_plus1_d = ifid_pc_plus1_q;
      ifid_valid_d    = ifid_valid_q;
      load_bubble     = 1'b0;
      fetch_inc       = 1'b0;
      bubble_inc      = 1'b0;

      unique case (state_q)
         StBoot: begin
            state_d     = StRun;
            load_bubble = 1'b1;
         end
         StRun: begin
            if (bus.redirect) begin
               // A redirect squashes the stall as well: the wrong-path slot becomes a bubble
               pc_d        = bus.redirect_pc;
               load_bubble = 1'b1;
               bubble_inc  = 1'b1;
            end else if (bus.halt_req) begin
               state_d     = StHalt;
               load_bubble = 1'b1;
            end else if (bus.stall) begin
               bubble_inc  = 1'b1;
            end else begin
               pc_d            = pc_plus1;
               ifid_instr_d    = bus.Instruction;
               ifid_pc_d       = pc_q;
               ifid_pc_plus1_d = pc_plus1;
               ifid_valid_d    = 1'b1;
               fetch_inc       = 1'b1;
            end
         end
         StHalt: begin
            load_bubble = 1'b1;
         end
         default: begin
            state_d     = StBoot;
            load_bubble = 1'b1;
         end
      endcase

      if (load_bubble) begin
         ifid_instr_d    = NOP_WORD;
         ifid_pc_d       = 32'd0;
         ifid_pc_plus1_d = 32'd0;
         ifid_valid_d    = 1'b0;
      end
   end

   // Saturating counters: stick at all-ones instead of wrapping
   always_comb begin
      fetch_cnt_d  = fetch_cnt_q;
      bubble_cnt_d = bubble_cnt_q;
      if (fetch_inc && (fetch_cnt_q != 16'hFFFF)) begin
         fetch_cnt_d = fetch_cnt_q + 16'd1;
      end
      if (bubble_inc && (bubble_cnt_q != 16'hFFFF)) begin
         bubble_cnt_d = bubble_cnt_q + 16'd1;
      end
   end

   // State, PC, IF/ID and counters; reset overrides every other input
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q         <= StBoot;
         pc_q            <= RESET_PC;
         ifid_instr_q    <= NOP_WORD;
         ifid_pc_q       <= 32'd0;
         ifid_pc_plus1_q <= 32'd0;
         ifid_valid_q    <= 1'b0;
         fetch_cnt_q     <= 16'd0;
         bubble_cnt_q    <= 16'd0;
      end else begin
         state_q         <= state_d;
         pc_q            <= pc_d;
         ifid_instr_q    <= ifid_instr_d;
         ifid_pc_q       <= ifid_pc_d;
         ifid_pc_plus1_q <= ifid_pc_plus1_d;
         ifid_valid_q    <= ifid_valid_d;
         fetch_cnt_q     <= fetch_cnt_d;
         bubble_cnt_q    <= bubble_cnt_d;
      end
   end

   // Address goes straight from the PC register to instruction memory
   assign bus.Address       = pc_q;
   assign bus.ifid_instr    = ifid_instr_q;
   assign bus.ifid_pc       = ifid_pc_q;
   assign bus.ifid_pc_plus1 = ifid_pc_plus1_q;
   assign bus.ifid_valid    = ifid_valid_q;
   assign bus.halted        = (state_q == StHalt);
   assign bus.fetch_cnt     = fetch_cnt_q;
   assign bus.bubble_cnt    = bubble_cnt_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios plus random traffic, checked by a scoreboard
// fed from a behavioural model of the fetch rules.
module tb_fetch_stage;

   localparam logic [31:0] RST_PC = 32'h0000_0000;
   localparam logic [31:0] NOP    = 32'h0000_0000;

   logic clk;
   logic rst_n;

   fetch_stage_if bus ();

   fetch_stage #(
      .RESET_PC (RST_PC),
      .NOP_WORD (NOP)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Instruction memory contents: fixed program at 0..3, hashed words elsewhere
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      case (a)
         32'd0:   return 32'h0001_8880;
         32'd1:   return 32'h0422_1880;
         32'd2:   return 32'h1025_20C0;
         32'd3:   return 32'h0806_2880;
         default: return (a * 32'h9E37_79B1) ^ 32'hC3A5_5A3C;
      endcase
   endfunction

   assign bus.Instruction = mem_word(bus.Address);

   typedef struct {
      logic [31:0] addr;
      logic [31:0] instr;
      logic [31:0] pc;
      logic [31:0] pc1;
      logic        valid;
      logic        halted;
      logic [15:0] fcnt;
      logic [15:0] bcnt;
      bit          chk;
      int          phase;
   } exp_t;

   exp_t sb_q[$];
   int   n_checks = 0;
   int   n_fail   = 0;
   int   phase    = 0;

   // Reference model state
   bit          m_boot;
   bit          m_halt;
   logic [31:0] m_pc;
   logic [31:0] m_instr;
   logic [31:0] m_ipc;
   logic [31:0] m_ipc1;
   logic        m_valid;
   int          m_fcnt;
   int          m_bcnt;

   function automatic void cmp(input string nm, input logic [31:0] got, input logic [31:0] exp,
                               input int ph);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s (phase %0d, t=%0t): got %h, expected %h", nm, ph, $time, got, exp);
      end
   endfunction

   function automatic void model_bubble();
      m_instr = NOP;
      m_ipc   = 32'd0;
      m_ipc1  = 32'd0;
      m_valid = 1'b0;
   endfunction

   // One clock of the reference model: what the outputs must be after the next edge
   function automatic void model_step(input bit rn, input bit st, input bit rd, input bit hr,
                                      input logic [31:0] rpc);
      if (!rn) begin
         m_boot = 1'b1;
         m_halt = 1'b0;
         m_pc   = RST_PC;
         m_fcnt = 0;
         m_bcnt = 0;
         model_bubble();
      end else if (m_boot) begin
         m_boot = 1'b0;
         model_bubble();
      end else if (m_halt) begin
         model_bubble();
      end else if (rd) begin
         m_pc   = rpc;
         m_bcnt = (m_bcnt < 65535) ? m_bcnt + 1 : 65535;
         model_bubble();
      end else if (hr) begin
         m_halt = 1'b1;
         model_bubble();
      end else if (st) begin
         m_bcnt = (m_bcnt < 65535) ? m_bcnt + 1 : 65535;
      end else begin
         m_instr = mem_word(m_pc);
         m_ipc   = m_pc;
         m_ipc1  = m_pc + 32'd1;
         m_valid = 1'b1;
         m_pc    = m_pc + 32'd1;
         m_fcnt  = (m_fcnt < 65535) ? m_fcnt + 1 : 65535;
      end
   endfunction

   // Drive one cycle of stimulus, queue the predicted outputs, and advance past the edge
   task automatic step(input bit rn, input bit st, input bit rd, input bit hr,
                       input logic [31:0] rpc, input bit chk = 1'b1);
      exp_t e;
      rst_n           = rn;
      bus.stall       = st;
      bus.redirect    = rd;
      bus.halt_req    = hr;
      bus.redirect_pc = rpc;
      model_step(rn, st, rd, hr, rpc);
      e.addr   = m_pc;
      e.instr  = m_instr;
      e.pc     = m_ipc;
      e.pc1    = m_ipc1;
      e.valid  = m_valid;
      e.halted = m_halt;
      e.fcnt   = 16'(m_fcnt);
      e.bcnt   = 16'(m_bcnt);
      e.chk    = chk;
      e.phase  = phase;
      sb_q.push_back(e);
      @(posedge clk);
      #2;
   endtask

   // Monitor: outputs are sampled 1 time unit after each rising edge
   exp_t me;
   always @(posedge clk) begin
      #1;
      if (sb_q.size() > 0) begin
         me = sb_q.pop_front();
         if (me.chk) begin
            cmp("Address",       bus.Address,                me.addr,           me.phase);
            cmp("ifid_instr",    bus.ifid_instr,             me.instr,          me.phase);
            cmp("ifid_pc",       bus.ifid_pc,                me.pc,             me.phase);
            cmp("ifid_pc_plus1", bus.ifid_pc_plus1,          me.pc1,            me.phase);
            cmp("ifid_valid",    {31'd0, bus.ifid_valid},    {31'd0, me.valid}, me.phase);
            cmp("halted",        {31'd0, bus.halted},        {31'd0, me.halted}, me.phase);
            cmp("fetch_cnt",     {16'd0, bus.fetch_cnt},     {16'd0, me.fcnt},  me.phase);
            cmp("bubble_cnt",    {16'd0, bus.bubble_cnt},    {16'd0, me.bcnt},  me.phase);
         end
      end
   end

   logic [31:0] prog [4];

   initial begin
      prog[0] = 32'h0001_8880;
      prog[1] = 32'h0422_1880;
      prog[2] = 32'h1025_20C0;
      prog[3] = 32'h0806_2880;
      rst_n           = 1'b0;
      bus.stall       = 1'b0;
      bus.redirect    = 1'b0;
      bus.halt_req    = 1'b0;
      bus.redirect_pc = 32'd0;
      @(negedge clk);

      // Straight-line fetch from reset
      phase = 1;
      step(0, 0, 0, 0, 0);
      cmp("rst_ifid_valid", {31'd0, bus.ifid_valid}, 32'd0, phase);
      cmp("rst_fetch_cnt", {16'd0, bus.fetch_cnt}, 32'd0, phase);
      step(1, 0, 0, 0, 0);
      cmp("boot_address", bus.Address, 32'd0, phase);
      for (int k = 0; k < 4; k++) begin
         step(1, 0, 0, 0, 0);
         cmp("seq_instr", bus.ifid_instr, prog[k], phase);
         cmp("seq_pc", bus.ifid_pc, 32'(k), phase);
      end
      cmp("seq_fetch_cnt", {16'd0, bus.fetch_cnt}, 32'd4, phase);

      // Stall for two cycles at PC=2
      phase = 2;
      step(0, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0);
      for (int k = 0; k < 2; k++) begin
         step(1, 1, 0, 0, 0);
         cmp("stall_address", bus.Address, 32'd2, phase);
         cmp("stall_ifid_pc", bus.ifid_pc, 32'd1, phase);
         cmp("stall_ifid_instr", bus.ifid_instr, 32'h0422_1880, phase);
      end
      cmp("stall_bubble_cnt", {16'd0, bus.bubble_cnt}, 32'd2, phase);
      step(1, 0, 0, 0, 0);
      cmp("resume_instr", bus.ifid_instr, 32'h1025_20C0, phase);

      // Redirect in the same cycle as stall
      phase = 3;
      step(1, 1, 1, 0, 32'h40);
      cmp("redir_address", bus.Address, 32'h40, phase);
      cmp("redir_valid", {31'd0, bus.ifid_valid}, 32'd0, phase);
      cmp("redir_bubble_cnt", {16'd0, bus.bubble_cnt}, 32'd3, phase);
      step(1, 0, 0, 0, 0);
      cmp("redir_ifid_pc", bus.ifid_pc, 32'h40, phase);

      // Random traffic, no halt or reset
      phase = 4;
      for (int i = 0; i < 300; i++) begin
         step(1, $urandom_range(0, 99) < 30, $urandom_range(0, 99) < 10, 0, $urandom());
      end

      // Halt at PC=5; redirect, stall and further fetch attempts are ignored
      phase = 5;
      step(1, 0, 1, 0, 32'd5);
      step(1, 0, 0, 1, 0);
      cmp("halt_halted", {31'd0, bus.halted}, 32'd1, phase);
      cmp("halt_address", bus.Address, 32'd5, phase);
      step(1, 0, 1, 0, 32'h99);
      step(1, 1, 0, 0, 0);
      for (int i = 0; i < 5; i++) step(1, 0, 0, 0, 0);
      cmp("halt_address_hold", bus.Address, 32'd5, phase);
      cmp("halt_valid", {31'd0, bus.ifid_valid}, 32'd0, phase);

      // Reset out of HALT, wrap at the top of the PC range, counter saturation
      phase = 6;
      step(0, 0, 0, 0, 0);
      cmp("rst_halt_halted", {31'd0, bus.halted}, 32'd0, phase);
      step(1, 0, 0, 0, 0);
      step(1, 0, 1, 0, 32'hFFFF_FFFF);
      step(1, 0, 0, 0, 0);
      cmp("wrap_address", bus.Address, 32'd0, phase);
      cmp("wrap_pc_plus1", bus.ifid_pc_plus1, 32'd0, phase);
      cmp("wrap_ifid_pc", bus.ifid_pc, 32'hFFFF_FFFF, phase);
      for (int i = 0; i < 70000; i++) begin
         step(1, 0, 0, 0, 0, (i % 4096 == 0) || (i == 69999));
      end
      cmp("sat_fetch_cnt", {16'd0, bus.fetch_cnt}, 32'h0000_FFFF, phase);

      // Reset during a stall with a concurrent redirect
      phase = 7;
      step(1, 1, 0, 0, 0);
      step(0, 1, 1, 0, 32'h123);
      cmp("rst_mid_address", bus.Address, RST_PC, phase);
      cmp("rst_mid_bubble_cnt", {16'd0, bus.bubble_cnt}, 32'd0, phase);
      cmp("rst_mid_fetch_cnt", {16'd0, bus.fetch_cnt}, 32'd0, phase);
      step(1, 0, 0, 0, 0);
      cmp("rst_boot_valid", {31'd0, bus.ifid_valid}, 32'd0, phase);
      step(1, 0, 0, 0, 0);
      cmp("rst_first_valid", {31'd0, bus.ifid_valid}, 32'd1, phase);
      cmp("rst_first_pc", bus.ifid_pc, RST_PC, phase);

      // Random traffic including occasional halt and reset
      phase = 8;
      for (int i = 0; i < 400; i++) begin
         step($urandom_range(0, 99) >= 2, $urandom_range(0, 99) < 25,
              $urandom_range(0, 99) < 10, $urandom_range(0, 99) < 3, $urandom());
      end

      @(posedge clk);
      #3;
      cmp("scoreboard_drained", 32'(sb_q.size()), 32'd0, phase);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
